td4_prog_loader: RTL and testbench

- Serial program writer for the TD4 CPU's 16 x 8 instruction store.
- Receives a UART byte stream (8N1, LSB first) and writes 16 instruction bytes into program memory at addresses 0..15.
- Holds the CPU in reset while loading and releases it once a complete image is written.
- Sits between the board RX pin and the program memory write port; the CPU's read side is unchanged.

---
 rtl/td4_prog_loader.sv | 357 +++++++++++++++++++++++++++++++++++
 tb/tb_td4_prog_loader.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/td4_prog_loader.sv
// -----------------------------------------------------------------------------
// td4_prog_loader
//
// Serial program writer for the TD4 CPU's 16 x 8 instruction store. A UART
// byte stream (8N1, LSB first) is received; the byte SYNC_BYTE starts a load.
// The next 16 bytes are written to program memory addresses 0..15. The CPU is
// held in reset while loading. It is released only after a complete image
// has been written, so it never runs an unloaded image.
//
// Optional build macro: TD4_LOADER_CHECKSUM_EN
//   When this macro is defined, a 17th byte must follow the 16 data bytes.
//   It must equal the modulo-256 sum of those 16 bytes. On a match the CPU is
//   released. On a mismatch or a frame error the loader returns to hunting
//   and the CPU stays in reset. The checksum byte is never written to memory.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per UART bit (legal range 4..65535)
//   SYNC_BYTE     byte value that starts a load
//
// Ports:
//   clock        in   system clock
//   reset        in   asynchronous active-low reset
//   rx           in   UART line, idle high, asynchronous to clock
//   mem_we       out  program memory write strobe (one-cycle pulse)
//   mem_addr     out  write address (held when mem_we is low)
//   mem_wdata    out  write data {Imm,OP} (held when mem_we is low)
//   cpu_reset_n  out  active-low CPU reset; low while loading or unloaded
//   busy         out  high from an accepted sync byte until the load ends
//   done         out  high while a valid image is loaded and the CPU runs
//   frame_err    out  sticky bad-stop-bit flag; cleared by an accepted sync
// -----------------------------------------------------------------------------
module td4_prog_loader #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic       mem_we,
  output logic [3:0] mem_addr,
  output logic [7:0] mem_wdata,
  output logic       cpu_reset_n,
  output logic       busy,
  output logic       done,
  output logic       frame_err
);

  // The last count value of a full bit period and of a half bit period.
  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_LAST = 16'((CLKS_PER_BIT / 2) - 1);

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

`ifdef TD4_LOADER_CHECKSUM_EN
  typedef enum logic [1:0] {
    LD_HUNT  = 2'd0,
    LD_LOAD  = 2'd1,
    LD_CHECK = 2'd2,
    LD_RUN   = 2'd3
  } ld_state_e;
`else
  typedef enum logic [1:0] {
    LD_HUNT = 2'd0,
    LD_LOAD = 2'd1,
    LD_RUN  = 2'd3
  } ld_state_e;
`endif

`ifdef TD4_LOADER_CHECKSUM_EN
  // Running modulo-256 checksum accumulation.
  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction
`endif

  // ---------------------------------------------------------------------------
  // Receiver signals
  // ---------------------------------------------------------------------------
  logic        rx_meta_q, rx_sync_q;
  rx_state_e   rx_state_q, rx_state_d;
  logic [15:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic        rx_valid_q, rx_valid_d;
  logic [7:0]  rx_byte_q, rx_byte_d;
  logic        rx_ferr_q, rx_ferr_d;

  // ---------------------------------------------------------------------------
  // Loader signals
  // ---------------------------------------------------------------------------
  ld_state_e   ld_state_q, ld_state_d;
  logic [3:0]  addr_q, addr_d;
  logic        mem_we_q, mem_we_d;
  logic [3:0]  mem_addr_q, mem_addr_d;
  logic [7:0]  mem_wdata_q, mem_wdata_d;
  logic        cpu_reset_n_q, cpu_reset_n_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        frame_err_q, frame_err_d;
`ifdef TD4_LOADER_CHECKSUM_EN
  logic [7:0]  sum_q, sum_d;
`endif

  // Two-flop synchroniser for the asynchronous rx line (idles high).
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  // Receiver next-state logic: centre-samples start, 8 data bits and stop.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_valid_d = 1'b0;
    rx_byte_d  = rx_byte_q;
    rx_ferr_d  = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = 16'd0;
        if (!rx_sync_q) begin
          rx_state_d = RX_START;
        end else begin
          rx_state_d = RX_IDLE;
        end
      end
      RX_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d = 16'd0;
          // A line that is back high at mid-start is treated as a glitch.
          if (rx_sync_q) begin
            rx_state_d = RX_IDLE;
          end else begin
            rx_state_d = RX_DATA;
            rx_bit_d   = 3'd0;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 16'd1;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = 16'd0;
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) begin
            rx_state_d = RX_STOP;
          end else begin
            rx_bit_d = rx_bit_q + 3'd1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 16'd1;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = 16'd0;
          rx_state_d = RX_IDLE;
          if (rx_sync_q) begin
            rx_valid_d = 1'b1;
            rx_byte_d  = rx_shift_q;
          end else begin
            rx_ferr_d = 1'b1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 16'd1;
        end
      end
      default: begin
        rx_state_d = RX_IDLE;
        rx_cnt_d   = 16'd0;
      end
    endcase
  end

  // Receiver state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= 16'd0;
      rx_bit_q   <= 3'd0;
      rx_shift_q <= 8'h00;
      rx_valid_q <= 1'b0;
      rx_byte_q  <= 8'h00;
      rx_ferr_q  <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_valid_q <= rx_valid_d;
      rx_byte_q  <= rx_byte_d;
      rx_ferr_q  <= rx_ferr_d;
    end
  end

  // Loader next-state and registered-output logic.
  always_comb begin
    ld_state_d    = ld_state_q;
    addr_d        = addr_q;
    mem_we_d      = 1'b0;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    cpu_reset_n_d = cpu_reset_n_q;
    busy_d        = busy_q;
    done_d        = done_q;
    // frame_err is sticky in every state; only an accepted sync clears it.
    frame_err_d   = frame_err_q | rx_ferr_q;
`ifdef TD4_LOADER_CHECKSUM_EN
    sum_d         = sum_q;
`endif
    case (ld_state_q)
      LD_HUNT: begin
        busy_d        = 1'b0;
        done_d        = 1'b0;
        cpu_reset_n_d = 1'b0;
        if (rx_valid_q && (rx_byte_q == SYNC_BYTE)) begin
          ld_state_d  = LD_LOAD;
          addr_d      = 4'd0;
          busy_d      = 1'b1;
          frame_err_d = 1'b0;
`ifdef TD4_LOADER_CHECKSUM_EN
          sum_d       = 8'h00;
`endif
        end else begin
          ld_state_d = LD_HUNT;
        end
      end
      LD_LOAD: begin
        if (rx_ferr_q) begin
          // Abort; memory already written is left as is.
          ld_state_d    = LD_HUNT;
          busy_d        = 1'b0;
          done_d        = 1'b0;
          cpu_reset_n_d = 1'b0;
        end else if (rx_valid_q) begin
          // Every byte is data here, including one equal to SYNC_BYTE.
          mem_we_d    = 1'b1;
          mem_addr_d  = addr_q;
          mem_wdata_d = rx_byte_q;
          addr_d      = addr_q + 4'd1;
`ifdef TD4_LOADER_CHECKSUM_EN
          sum_d       = csum_add(sum_q, rx_byte_q);
`endif
          if (addr_q == 4'd15) begin
`ifdef TD4_LOADER_CHECKSUM_EN
            ld_state_d = LD_CHECK;
`else
            ld_state_d = LD_RUN;
`endif
          end else begin
            ld_state_d = LD_LOAD;
          end
        end else begin
          ld_state_d = LD_LOAD;
        end
      end
`ifdef TD4_LOADER_CHECKSUM_EN
      LD_CHECK: begin
        if (rx_ferr_q) begin
          ld_state_d    = LD_HUNT;
          busy_d        = 1'b0;
          done_d        = 1'b0;
          cpu_reset_n_d = 1'b0;
        end else if (rx_valid_q) begin
          if (rx_byte_q == sum_q) begin
            ld_state_d = LD_RUN;
          end else begin
            ld_state_d    = LD_HUNT;
            busy_d        = 1'b0;
            done_d        = 1'b0;
            cpu_reset_n_d = 1'b0;
          end
        end else begin
          ld_state_d = LD_CHECK;
        end
      end
`endif
      LD_RUN: begin
        if (rx_valid_q && (rx_byte_q == SYNC_BYTE)) begin
          // Restart: the CPU goes back into reset immediately.
          ld_state_d    = LD_LOAD;
          addr_d        = 4'd0;
          busy_d        = 1'b1;
          done_d        = 1'b0;
          cpu_reset_n_d = 1'b0;
          frame_err_d   = 1'b0;
`ifdef TD4_LOADER_CHECKSUM_EN
          sum_d         = 8'h00;
`endif
        end else begin
          // Entering RUN releases the CPU one cycle after the final write.
          ld_state_d    = LD_RUN;
          busy_d        = 1'b0;
          done_d        = 1'b1;
          cpu_reset_n_d = 1'b1;
        end
      end
      default: begin
        ld_state_d    = LD_HUNT;
        busy_d        = 1'b0;
        done_d        = 1'b0;
        cpu_reset_n_d = 1'b0;
      end
    endcase
  end

  // Loader state and output registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ld_state_q    <= LD_HUNT;
      addr_q        <= 4'd0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= 4'd0;
      mem_wdata_q   <= 8'h00;
      cpu_reset_n_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      frame_err_q   <= 1'b0;
`ifdef TD4_LOADER_CHECKSUM_EN
      sum_q         <= 8'h00;
`endif
    end else begin
      ld_state_q    <= ld_state_d;
      addr_q        <= addr_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      cpu_reset_n_q <= cpu_reset_n_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      frame_err_q   <= frame_err_d;
`ifdef TD4_LOADER_CHECKSUM_EN
      sum_q         <= sum_d;
`endif
    end
  end

  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign cpu_reset_n = cpu_reset_n_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_td4_prog_loader.sv
// -----------------------------------------------------------------------------
// tb_td4_prog_loader
//
// Directed bench for td4_prog_loader with CLKS_PER_BIT=8 and SYNC_BYTE=A5.
// UART frames are driven on rx. A monitor logs every mem_we pulse. After each
// scenario, the write log and the status outputs are compared with values the
// bench computes itself. If TD4_LOADER_CHECKSUM_EN is defined, it follows the
// checksum build.
// -----------------------------------------------------------------------------
module tb_td4_prog_loader;

  localparam int CPB = 8;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       rx    = 1'b1;
  logic       mem_we;
  logic [3:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       cpu_reset_n;
  logic       busy;
  logic       done;
  logic       frame_err;

  int total_cnt = 0;
  int bad_cnt   = 0;

  // Write log filled by the monitor.
  logic [3:0] wr_addr [512];
  logic [7:0] wr_data [512];
  int         wr_cnt        = 0;
  logic       prev_we       = 1'b0;
  logic       double_we     = 1'b0;
  logic       done_at_we    = 1'b0;
  logic       done_after_we = 1'b0;
  logic       cpu_after_we  = 1'b0;

  logic [7:0] img [16];

  td4_prog_loader #(
    .CLKS_PER_BIT(CPB),
    .SYNC_BYTE   (8'hA5)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .rx         (rx),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .cpu_reset_n(cpu_reset_n),
    .busy       (busy),
    .done       (done),
    .frame_err  (frame_err)
  );

  always #5 clock = ~clock;

  // Write monitor, sampled on the inactive edge.
  always @(negedge clock) begin
    if (prev_we) begin
      done_after_we = done;
      cpu_after_we  = cpu_reset_n;
    end
    if (mem_we) begin
      if (prev_we) double_we = 1'b1;
      if (wr_cnt < 512) begin
        wr_addr[wr_cnt] = mem_addr;
        wr_data[wr_cnt] = mem_wdata;
      end
      wr_cnt     = wr_cnt + 1;
      done_at_we = done;
    end
    prev_we = mem_we;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt = total_cnt + 1;
    if (got !== exp) begin
      bad_cnt = bad_cnt + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    @(negedge clock);
    rx = 1'b0;
    repeat (CPB) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clock);
    end
    rx = stop_bit;
    repeat (CPB) @(negedge clock);
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clock);
  endtask

  task automatic send_image();
    logic [7:0] s;
    s = 8'h00;
    for (int i = 0; i < 16; i++) begin
      send_byte(img[i], 1'b1);
      s = s + img[i];
    end
`ifdef TD4_LOADER_CHECKSUM_EN
    send_byte(s, 1'b1);
`endif
  endtask

  task automatic check_writes(input string tag, input int base);
    check({tag, "_count"}, wr_cnt - base, 16);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("%s_addr%0d", tag, i), {28'd0, wr_addr[base + i]}, i);
      check($sformatf("%s_data%0d", tag, i), {24'd0, wr_data[base + i]}, {24'd0, img[i]});
    end
  endtask

  task automatic check_run(input string tag);
    check({tag, "_done"}, done, 1);
    check({tag, "_cpu"}, cpu_reset_n, 1);
    check({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    int base;

    // Reset and idle line.
    repeat (5) @(negedge clock);
    check("rst_cpu", cpu_reset_n, 0);
    check("rst_we", mem_we, 0);
    reset = 1'b1;
    repeat (1000) @(negedge clock);
    check("idle_writes", wr_cnt, 0);
    check("idle_cpu", cpu_reset_n, 0);
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);
    check("idle_ferr", frame_err, 0);
    check("idle_addr", {28'd0, mem_addr}, 0);
    check("idle_wdata", {24'd0, mem_wdata}, 0);

    // Load bytes 00..0F.
    base = wr_cnt;
    send_byte(8'hA5, 1'b1);
    check("l1_busy", busy, 1);
    check("l1_cpu_hold", cpu_reset_n, 0);
    for (int i = 0; i < 16; i++) img[i] = 8'(i);
    send_image();
    check_writes("l1", base);
    check_run("l1");
    check("l1_done_at_last_we", done_at_we, 0);
`ifdef TD4_LOADER_CHECKSUM_EN
    check("l1_done_after_we", done_after_we, 0);
    check("l1_cpu_after_we", cpu_after_we, 0);
`else
    check("l1_done_after_we", done_after_we, 1);
    check("l1_cpu_after_we", cpu_after_we, 1);
`endif

    // Non-sync bytes in RUN are ignored; A5 restarts with B7 image.
    base = wr_cnt;
    send_byte(8'h3C, 1'b1);
    send_byte(8'hFF, 1'b1);
    check("ign_writes", wr_cnt - base, 0);
    check_run("ign");
    send_byte(8'hA5, 1'b1);
    check("rst_run_cpu", cpu_reset_n, 0);
    check("rst_run_done", done, 0);
    check("rst_run_busy", busy, 1);
    for (int i = 0; i < 16; i++) img[i] = 8'hB7;
    send_image();
    check_writes("b7", base);
    check_run("b7");

    // Frame error after 5 data bytes aborts the load.
    base = wr_cnt;
    send_byte(8'hA5, 1'b1);
    for (int i = 0; i < 5; i++) send_byte(8'h11 + 8'(i), 1'b1);
    send_byte(8'h6E, 1'b0);
    check("fe_writes", wr_cnt - base, 5);
    check("fe_ferr", frame_err, 1);
    check("fe_busy", busy, 0);
    check("fe_cpu", cpu_reset_n, 0);
    check("fe_done", done, 0);
    repeat (200) @(negedge clock);
    check("fe_no_more_writes", wr_cnt - base, 5);
    check("fe_ferr_sticky", frame_err, 1);

    // New sync clears frame_err; image includes A5 as a data byte.
    base = wr_cnt;
    send_byte(8'hA5, 1'b1);
    check("fe_clr_ferr", frame_err, 0);
    check("fe_clr_busy", busy, 1);
    for (int i = 0; i < 16; i++) img[i] = 8'hA0 + 8'(i);
    send_image();
    check_writes("a0", base);
    check_run("a0");

    // Two-cycle low glitch on idle rx.
    base = wr_cnt;
    @(negedge clock);
    rx = 1'b0;
    repeat (2) @(negedge clock);
    rx = 1'b1;
    repeat (200) @(negedge clock);
    check("gl_writes", wr_cnt - base, 0);
    check("gl_ferr", frame_err, 0);
    check_run("gl");

    // Frame error while running: flag only, CPU keeps running.
    send_byte(8'h55, 1'b0);
    check("run_fe_ferr", frame_err, 1);
    check_run("run_fe");

`ifdef TD4_LOADER_CHECKSUM_EN
    // Wrong checksum: image written but CPU never released.
    base = wr_cnt;
    send_byte(8'hA5, 1'b1);
    check("cs_ferr_clr", frame_err, 0);
    for (int i = 0; i < 16; i++) begin
      img[i] = 8'(i);
      send_byte(img[i], 1'b1);
    end
    send_byte(8'h00, 1'b1);
    check_writes("cs", base);
    check("cs_done", done, 0);
    check("cs_cpu", cpu_reset_n, 0);
    check("cs_busy", busy, 0);
`endif

    // Reset in the middle of a load.
    base = wr_cnt;
    send_byte(8'hA5, 1'b1);
    for (int i = 0; i < 3; i++) send_byte(8'h40 + 8'(i), 1'b1);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("mr_cpu", cpu_reset_n, 0);
    check("mr_busy", busy, 0);
    check("mr_ferr", frame_err, 0);
    check("mr_addr", {28'd0, mem_addr}, 0);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (300) @(negedge clock);
    check("mr_writes", wr_cnt - base, 3);
    check("mr_done", done, 0);
    check("mr_cpu_after", cpu_reset_n, 0);

    check("no_double_we", double_we, 0);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
